// File: rtl/neuron_result_writeback_pkg.sv
// Shared constants and types for the neuron result write-back path.
package neuron_result_writeback_pkg;

  localparam int NEURO_DATA_W = 16;
  localparam int NEURO_ADDR_W = 16;

  // Drain FSM state: IDLE waits for a buffered result, REQ holds a write until acked.
  typedef enum logic [0:0] {
    WB_IDLE = 1'b0,
    WB_REQ  = 1'b1
  } wbState_t;

  // A layer completes when counting is enabled and the post-increment count hits the target.
  function automatic logic layerHit(input logic [15:0] nextCount, input logic [15:0] target);
    return (target != 16'd0) && (nextCount == target);
  endfunction

endpackage

// File: rtl/neuron_result_writeback_fifo.sv
// Small synchronous FIFO with head and head+1 peek ports.
// A push is accepted when full if a pop happens on the same edge.
module neuro_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head,
  output logic [WIDTH-1:0]         nextHead,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] rdPtrNxt;
  logic             doPush;
  logic             doPop;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign doPop    = pop && !empty;
  assign doPush   = push && (!full || doPop);
  assign rdPtrNxt = rdPtr + PTR_W'(1);
  assign head     = mem[rdPtr];
  assign nextHead = mem[rdPtrNxt];

  // Storage: data only, no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= wdata;
  end

  // Pointers wrap naturally (power-of-two depth); count carries the extra bit for full/empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtrNxt;
      unique case ({doPush, doPop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/neuron_result_writeback.sv
// Captures activation results, buffers them and drains them to the neuron-value
// memory through a req/ack handshake; pulses layer_done per completed layer.
module neuron_result_writeback
  import neuron_result_writeback_pkg::*;
#(
  parameter int DATA_W     = NEURO_DATA_W,
  parameter int ADDR_W     = NEURO_ADDR_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_val,
  input  logic [ADDR_W-1:0] in_dest,
  input  logic              in_we,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [15:0]       layer_target,
  output logic              layer_done,
  output logic              busy,
  output logic              full,
  output logic              overflow
);

  localparam int ENT_W = ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  wbState_t         state;
  logic [ENT_W-1:0] fifoHead;
  logic [ENT_W-1:0] fifoNext;
  logic             fifoFull;
  logic             fifoEmpty;
  logic [CNT_W-1:0] fifoCount;
  logic             ackTake;
  logic [15:0]      layerCount;
  logic [15:0]      layerCountInc;

  // The in-flight write stays in the FIFO until acked, so pop == accepted write.
  assign ackTake       = mem_req && mem_ack;
  assign layerCountInc = layerCount + 16'd1;
  assign busy          = !fifoEmpty || mem_req;
  assign full          = fifoFull;

  neuro_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .clk      (clk),
    .rst      (rst),
    .push     (in_we),
    .pop      (ackTake),
    .wdata    ({in_dest, in_val}),
    .head     (fifoHead),
    .nextHead (fifoNext),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  // Drain FSM: present the head, hold it until ack, chain straight into the next entry if one is queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= WB_IDLE;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      unique case (state)
        WB_IDLE: begin
          if (!fifoEmpty) begin
            {mem_addr, mem_wdata} <= fifoHead;
            mem_req               <= 1'b1;
            state                 <= WB_REQ;
          end
        end
        WB_REQ: begin
          if (ackTake) begin
            if (fifoCount > CNT_W'(1)) begin
              {mem_addr, mem_wdata} <= fifoNext;
            end else begin
              mem_req <= 1'b0;
              state   <= WB_IDLE;
            end
          end
        end
        default: begin
          mem_req <= 1'b0;
          state   <= WB_IDLE;
        end
      endcase
    end
  end

  // Layer counter: counts acked writes, restarts and pulses done when the live target is hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      layerCount <= 16'd0;
      layer_done <= 1'b0;
    end else begin
      layer_done <= 1'b0;
      if (ackTake) begin
        if (layerHit(layerCountInc, layer_target)) begin
          layerCount <= 16'd0;
          layer_done <= 1'b1;
        end else begin
          layerCount <= layerCountInc;
        end
      end
    end
  end

  // Sticky drop flag: a result arriving at a full FIFO with no simultaneous pop is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               overflow <= 1'b0;
    else if (in_we && fifoFull && !ackTake) overflow <= 1'b1;
  end

endmodule

// File: tb/tb_neuron_result_writeback.sv
// Directed bench for neuron_result_writeback: reset, single write, backpressure,
// back-to-back, layer counting, full push+pop, async reset mid-request.
module tb_neuron_result_writeback;

  logic        clk;
  logic        rst;
  logic [15:0] in_val;
  logic [15:0] in_dest;
  logic        in_we;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] layer_target;
  logic        layer_done;
  logic        busy;
  logic        full;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  logic [15:0] gotA [$];
  logic [15:0] gotD [$];

  neuron_result_writeback #(
    .DATA_W     (16),
    .ADDR_W     (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_val       (in_val),
    .in_dest      (in_dest),
    .in_we        (in_we),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .layer_target (layer_target),
    .layer_done   (layer_done),
    .busy         (busy),
    .full         (full),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  // Sample the write presented before the coming edge (caller holds mem_ack=1).
  task automatic recTick();
    if (mem_req) begin
      gotA.push_back(mem_addr);
      gotD.push_back(mem_wdata);
    end
    tick();
  endtask

  initial begin
    int doneCnt;
    int reqCycles;
    int firstC;
    int lastC;

    rst = 1'b1; in_val = '0; in_dest = '0; in_we = 1'b0; mem_ack = 1'b0; layer_target = 16'd0;
    tick();
    chk("rst_req",      mem_req,    0);
    chk("rst_addr",     mem_addr,   0);
    chk("rst_wdata",    mem_wdata,  0);
    chk("rst_done",     layer_done, 0);
    chk("rst_busy",     busy,       0);
    chk("rst_full",     full,       0);
    chk("rst_overflow", overflow,   0);
    rst = 1'b0;

    // Single write
    in_we = 1'b1; in_val = 16'h1234; in_dest = 16'h0005;
    tick();
    in_we = 1'b0;
    chk("single_req_lat0", mem_req, 0);
    chk("single_busy",     busy,    1);
    tick();
    chk("single_req",  mem_req,   1);
    chk("single_addr", mem_addr,  16'h0005);
    chk("single_data", mem_wdata, 16'h1234);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("single_req_drop", mem_req, 0);
    chk("single_busy_drop", busy,   0);

    // Backpressure: 5 pulses into a 4-deep FIFO with ack held low
    for (int i = 0; i < 5; i++) begin
      in_we = 1'b1; in_val = 16'(16'h00A0 + i); in_dest = 16'(16'h0010 + i);
      tick();
    end
    in_we = 1'b0;
    chk("bp_full",     full,     1);
    chk("bp_overflow", overflow, 1);
    chk("bp_req",      mem_req,  1);
    chk("bp_addr_hold", mem_addr, 16'h0010);
    tick();
    chk("bp_addr_hold2", mem_addr, 16'h0010);
    mem_ack = 1'b1;
    gotA.delete(); gotD.delete();
    for (int c = 0; c < 8; c++) recTick();
    mem_ack = 1'b0;
    chk("bp_nwrites", gotA.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < gotA.size()) begin
        chk($sformatf("bp_addr%0d", i), gotA[i], 16'(16'h0010 + i));
        chk($sformatf("bp_data%0d", i), gotD[i], 16'(16'h00A0 + i));
      end
    end
    chk("bp_overflow_sticky", overflow, 1);
    chk("bp_idle_busy", busy, 0);

    // Back-to-back with ack tied high
    mem_ack = 1'b1;
    gotA.delete(); gotD.delete();
    reqCycles = 0; firstC = -1; lastC = -1;
    for (int c = 0; c < 14; c++) begin
      in_we = (c < 8); in_val = 16'(16'h0100 + c); in_dest = 16'(16'h0200 + c);
      if (mem_req) begin
        reqCycles++;
        if (firstC < 0) firstC = c;
        lastC = c;
      end
      recTick();
    end
    in_we = 1'b0;
    chk("b2b_nwrites", gotA.size(), 8);
    chk("b2b_reqcycles", reqCycles, 8);
    chk("b2b_continuous", lastC - firstC, 7);
    for (int i = 0; i < 8; i++) begin
      if (i < gotA.size()) begin
        chk($sformatf("b2b_addr%0d", i), gotA[i], 16'(16'h0200 + i));
        chk($sformatf("b2b_data%0d", i), gotD[i], 16'(16'h0100 + i));
      end
    end

    // Layer counting from a clean count; also clears sticky overflow
    pulseReset();
    chk("rst_clears_overflow", overflow, 0);
    layer_target = 16'd3;
    for (int k = 0; k < 10; k++) begin
      in_we = (k < 6); in_val = 16'(16'h0300 + k); in_dest = 16'(k);
      tick();
      chk($sformatf("layer_done_c%0d", k), layer_done, (k == 4 || k == 7));
    end
    in_we = 1'b0;

    // Counting disabled: no pulse ever
    layer_target = 16'd0;
    doneCnt = 0;
    for (int k = 0; k < 8; k++) begin
      in_we = (k < 4); in_val = 16'(k); in_dest = 16'(k);
      tick();
      if (layer_done) doneCnt++;
    end
    in_we = 1'b0;
    chk("target0_nodone", doneCnt, 0);

    // Full FIFO, push on the ack edge is accepted
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_we = 1'b1; in_val = 16'(16'h00C0 + i); in_dest = 16'(16'h0030 + i);
      tick();
    end
    chk("pp_full", full, 1);
    chk("pp_req",  mem_req, 1);
    gotA.delete(); gotD.delete();
    in_we = 1'b1; in_val = 16'h00C4; in_dest = 16'h0034; mem_ack = 1'b1;
    recTick();
    in_we = 1'b0;
    chk("pp_overflow", overflow, 0);
    chk("pp_still_full", full, 1);
    for (int c = 0; c < 8; c++) recTick();
    mem_ack = 1'b0;
    chk("pp_nwrites", gotA.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < gotA.size()) chk($sformatf("pp_data%0d", i), gotD[i], 16'(16'h00C0 + i));
    end

    // Async reset while a request is outstanding
    layer_target = 16'd2;
    in_we = 1'b1; in_val = 16'h00F0; in_dest = 16'h0040;
    tick();
    in_we = 1'b0;
    tick();
    chk("mid_req_before", mem_req, 1);
    rst = 1'b1;
    #2;
    chk("mid_req_async", mem_req,  0);
    chk("mid_busy",      busy,     0);
    chk("mid_addr",      mem_addr, 0);
    rst = 1'b0;
    mem_ack = 1'b1;
    in_we = 1'b1; in_val = 16'h00F1; in_dest = 16'h0041;
    tick();
    in_we = 1'b0;
    doneCnt = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (layer_done) doneCnt++;
    end
    chk("mid_count_cleared_nodone", doneCnt, 0);
    in_we = 1'b1; in_val = 16'h00F2; in_dest = 16'h0042;
    tick();
    in_we = 1'b0;
    doneCnt = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (layer_done) doneCnt++;
    end
    chk("mid_second_done", doneCnt, 1);
    mem_ack = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
